ps2_direction_decoder: RTL and testbench



---
 rtl/ps2_direction_decoder_pkg.sv | 71 +++++++
 rtl/ps2_direction_decoder_repeat_timer.sv | 38 +++
 rtl/ps2_direction_decoder.sv | 129 ++++++++++++
 tb/tb_ps2_direction_decoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_direction_decoder_pkg.sv
// Shared constants for the PS/2 direction decoder: set-2 scancodes,
// prefix FSM state encoding, direction indices and small helpers.
package ps2_direction_decoder_pkg;

  // Prefix and control bytes
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_BAT = 8'hAA;

  // Extended (E0-prefixed) arrow keys
  localparam logic [7:0] SC_UP_EXT    = 8'h75;
  localparam logic [7:0] SC_DOWN_EXT  = 8'h72;
  localparam logic [7:0] SC_LEFT_EXT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT_EXT = 8'h74;

  // Non-extended WASD aliases
  localparam logic [7:0] SC_UP    = 8'h1D;
  localparam logic [7:0] SC_DOWN  = 8'h1B;
  localparam logic [7:0] SC_LEFT  = 8'h1C;
  localparam logic [7:0] SC_RIGHT = 8'h23;

  // Prefix FSM states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  // Direction indices into a direction vector
  localparam int unsigned DIR_UP    = 0;
  localparam int unsigned DIR_DOWN  = 1;
  localparam int unsigned DIR_LEFT  = 2;
  localparam int unsigned DIR_RIGHT = 3;
  localparam int unsigned NUM_DIRS  = 4;

  typedef logic [NUM_DIRS-1:0] dir_vec_t;

  // One-hot direction for a key code; zero when the code is not mapped.
  function automatic dir_vec_t decode_key(input logic [7:0] code, input logic ext);
    dir_vec_t v;
    v = '0;
    if (ext) begin
      case (code)
        SC_UP_EXT:    v[DIR_UP]    = 1'b1;
        SC_DOWN_EXT:  v[DIR_DOWN]  = 1'b1;
        SC_LEFT_EXT:  v[DIR_LEFT]  = 1'b1;
        SC_RIGHT_EXT: v[DIR_RIGHT] = 1'b1;
        default:      v = '0;
      endcase
    end else begin
      case (code)
        SC_UP:    v[DIR_UP]    = 1'b1;
        SC_DOWN:  v[DIR_DOWN]  = 1'b1;
        SC_LEFT:  v[DIR_LEFT]  = 1'b1;
        SC_RIGHT: v[DIR_RIGHT] = 1'b1;
        default:  v = '0;
      endcase
    end
    return v;
  endfunction

  // Swap each direction with its opposite (up<->down, left<->right).
  function automatic dir_vec_t opposite(input dir_vec_t v);
    dir_vec_t o;
    o[DIR_UP]    = v[DIR_DOWN];
    o[DIR_DOWN]  = v[DIR_UP];
    o[DIR_LEFT]  = v[DIR_RIGHT];
    o[DIR_RIGHT] = v[DIR_LEFT];
    return o;
  endfunction

endpackage

// File: rtl/ps2_direction_decoder_repeat_timer.sv
// Auto-repeat countdown. Zero means idle; a load starts the initial delay,
// and each time the count sits at 1 it signals expiry and reloads the period.
module ps2_direction_decoder_repeat_timer #(
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000,
  parameter int unsigned TIMER_W       = 25
) (
  input  logic clock,
  input  logic resetn,
  input  logic load,
  input  logic clear,
  output logic expire
);

  localparam logic [TIMER_W-1:0] DELAY_V  = TIMER_W'(REPEAT_DELAY);
  localparam logic [TIMER_W-1:0] PERIOD_V = TIMER_W'(REPEAT_PERIOD);
  localparam logic [TIMER_W-1:0] ONE_V    = TIMER_W'(1);

  logic [TIMER_W-1:0] count_q;

  assign expire = (count_q == ONE_V);

  // Countdown register: clear beats load, load beats the periodic reload.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= DELAY_V;
    end else if (expire) begin
      count_q <= PERIOD_V;
    end else if (count_q != '0) begin
      count_q <= count_q - ONE_V;
    end
  end

endmodule

// File: rtl/ps2_direction_decoder.sv
// Turns the PS/2 set-2 byte stream into held-direction levels and one-cycle
// step pulses with auto-repeat, for driving the VGA sprite in fixed steps.
module ps2_direction_decoder
  import ps2_direction_decoder_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000,
  parameter int unsigned TIMER_W       = 25
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       step_left,
  output logic       step_right,
  output logic       step_up,
  output logic       step_down
);

  logic [1:0] state;
  logic [1:0] state_next;
  dir_vec_t   held;
  dir_vec_t   held_next;
  dir_vec_t   step_q;
  dir_vec_t   step_next;
  dir_vec_t   make_vec;
  dir_vec_t   brk_vec;
  dir_vec_t   new_make;
  logic       clear_all;
  logic       expire;
  logic       timer_load;
  logic       timer_clear;

  // Prefix decode: classify the strobed byte as make, break or self-test.
  always_comb begin
    state_next = state;
    make_vec   = '0;
    brk_vec    = '0;
    clear_all  = 1'b0;
    if (ps2_key_pressed) begin
      case (state)
        ST_IDLE: begin
          if (ps2_key_data == SC_EXT) begin
            state_next = ST_EXT;
          end else if (ps2_key_data == SC_BRK) begin
            state_next = ST_BRK;
          end else if (ps2_key_data == SC_BAT) begin
            clear_all = 1'b1;
          end else begin
            make_vec = decode_key(ps2_key_data, 1'b0);
          end
        end
        ST_EXT: begin
          if (ps2_key_data == SC_BRK) begin
            state_next = ST_EXT_BRK;
          end else begin
            make_vec   = decode_key(ps2_key_data, 1'b1);
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          brk_vec    = decode_key(ps2_key_data, 1'b0);
          state_next = ST_IDLE;
        end
        default: begin
          brk_vec    = decode_key(ps2_key_data, 1'b1);
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Held/step update. Steps are filtered against the post-update held set so
  // that a same-cycle make, break or expiry all see one consistent view, and
  // a make plus an expiry on one direction still yields a single pulse.
  always_comb begin
    new_make    = make_vec & ~held;
    held_next   = clear_all ? '0 : ((held | new_make) & ~brk_vec);
    step_next   = (new_make | (expire ? held_next : '0)) & ~opposite(held_next);
    timer_load  = |new_make;
    timer_clear = ~|held_next;
  end

  // Prefix FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered held levels and step pulses.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      held   <= '0;
      step_q <= '0;
    end else begin
      held   <= held_next;
      step_q <= step_next;
    end
  end

  ps2_direction_decoder_repeat_timer #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .TIMER_W       (TIMER_W)
  ) u_repeat_timer (
    .clock  (clock),
    .resetn (resetn),
    .load   (timer_load),
    .clear  (timer_clear),
    .expire (expire)
  );

  assign up         = held[DIR_UP];
  assign down       = held[DIR_DOWN];
  assign left       = held[DIR_LEFT];
  assign right      = held[DIR_RIGHT];
  assign step_up    = step_q[DIR_UP];
  assign step_down  = step_q[DIR_DOWN];
  assign step_left  = step_q[DIR_LEFT];
  assign step_right = step_q[DIR_RIGHT];

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Testbench for ps2_direction_decoder: directed scenarios followed by random
// byte traffic, all compared every cycle against a reference model that keeps
// the next repeat time as an absolute cycle number.
module tb_ps2_direction_decoder;

  localparam int DELAY  = 20;
  localparam int PERIOD = 5;

  logic       clock;
  logic       resetn;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic       left, right, up, down;
  logic       step_left, step_right, step_up, step_down;

  int n_cmp;
  int n_bad;

  // Reference model state (direction order: 0=up 1=down 2=left 3=right)
  bit     m_held [4];
  bit     m_step [4];
  bit     pre_e0;
  bit     pre_f0;
  longint edge_no;
  longint next_fire;

  ps2_direction_decoder #(
    .REPEAT_DELAY  (DELAY),
    .REPEAT_PERIOD (PERIOD),
    .TIMER_W       (8)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .left            (left),
    .right           (right),
    .up              (up),
    .down            (down),
    .step_left       (step_left),
    .step_right      (step_right),
    .step_up         (step_up),
    .step_down       (step_down)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Direction for a key code, or -1 when the code is not a direction key.
  function automatic int key_dir(input logic [7:0] b, input bit ext);
    logic [7:0] ext_codes [4];
    logic [7:0] std_codes [4];
    ext_codes = '{8'h75, 8'h72, 8'h6B, 8'h74};
    std_codes = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    for (int d = 0; d < 4; d++) begin
      if ((ext ? ext_codes[d] : std_codes[d]) == b) return d;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_held[d] = 1'b0;
      m_step[d] = 1'b0;
    end
    pre_e0    = 1'b0;
    pre_f0    = 1'b0;
    next_fire = -1;
  endtask

  // Advance the model across one active clock edge.
  task automatic model_edge(input bit stb, input logic [7:0] b);
    bit fresh [4];
    bit brk   [4];
    bit clr;
    bit expire;
    bit any_fresh;
    bit any_held;
    int d;
    for (int i = 0; i < 4; i++) begin
      fresh[i] = 1'b0;
      brk[i]   = 1'b0;
    end
    clr = 1'b0;
    edge_no++;
    expire = (edge_no == next_fire);
    if (stb) begin
      if (pre_f0) begin
        d = key_dir(b, pre_e0);
        if (d >= 0) brk[d] = 1'b1;
        pre_e0 = 1'b0;
        pre_f0 = 1'b0;
      end else if (pre_e0) begin
        if (b == 8'hF0) begin
          pre_f0 = 1'b1;
        end else begin
          d = key_dir(b, 1'b1);
          if (d >= 0 && !m_held[d]) fresh[d] = 1'b1;
          pre_e0 = 1'b0;
        end
      end else if (b == 8'hE0) begin
        pre_e0 = 1'b1;
      end else if (b == 8'hF0) begin
        pre_f0 = 1'b1;
      end else if (b == 8'hAA) begin
        clr = 1'b1;
      end else begin
        d = key_dir(b, 1'b0);
        if (d >= 0 && !m_held[d]) fresh[d] = 1'b1;
      end
    end
    any_fresh = 1'b0;
    any_held  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (fresh[i]) m_held[i] = 1'b1;
      if (brk[i] || clr) m_held[i] = 1'b0;
      any_fresh |= fresh[i];
    end
    for (int i = 0; i < 4; i++) begin
      any_held |= m_held[i];
      m_step[i] = (fresh[i] || (expire && m_held[i])) && !m_held[i ^ 1];
    end
    if (expire) next_fire = edge_no + PERIOD;
    if (any_fresh) next_fire = edge_no + DELAY;
    if (!any_held) next_fire = -1;
  endtask

  task automatic check(input string tag);
    logic [3:0] obs_h, exp_h, obs_s, exp_s;
    obs_h = {up, down, left, right};
    exp_h = {m_held[0], m_held[1], m_held[2], m_held[3]};
    obs_s = {step_up, step_down, step_left, step_right};
    exp_s = {m_step[0], m_step[1], m_step[2], m_step[3]};
    n_cmp++;
    assert (obs_h === exp_h) else begin
      n_bad++;
      $error("FAIL %s held{u,d,l,r} observed=%b expected=%b at edge %0d", tag, obs_h, exp_h, edge_no);
    end
    n_cmp++;
    assert (obs_s === exp_s) else begin
      n_bad++;
      $error("FAIL %s step{u,d,l,r} observed=%b expected=%b at edge %0d", tag, obs_s, exp_s, edge_no);
    end
  endtask

  // One clock cycle, optionally carrying a strobed byte; checked 1 time unit after the edge.
  task automatic cyc(input bit stb, input logic [7:0] b, input string tag);
    ps2_key_pressed = stb;
    ps2_key_data    = stb ? b : 8'($urandom);
    @(posedge clock);
    model_edge(stb, b);
    #1;
    check(tag);
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    cyc(1'b1, b, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, tag);
  endtask

  initial begin
    n_cmp           = 0;
    n_bad           = 0;
    edge_no         = 0;
    resetn          = 1'b0;
    ps2_key_pressed = 1'b0;
    ps2_key_data    = 8'h00;
    model_reset();
    #12;
    resetn = 1'b1;
    check("reset_state");

    // Extended make, then auto-repeat at +20, +25, +30
    send(8'hE0, "ext_make");
    send(8'h75, "ext_make");
    idle(35, "repeat_sched");

    // Extended break: flag drops, no pulse, no further repeats
    send(8'hE0, "ext_break");
    send(8'hF0, "ext_break");
    send(8'h75, "ext_break");
    idle(30, "after_break");

    // Typematic re-makes every 3 cycles must not shift the schedule
    send(8'hE0, "typematic");
    send(8'h75, "typematic");
    for (int i = 0; i < 8; i++) begin
      idle(1, "typematic");
      send(8'hE0, "typematic");
      send(8'h75, "typematic");
    end
    idle(20, "typematic");
    send(8'hE0, "typematic_rel");
    send(8'hF0, "typematic_rel");
    send(8'h75, "typematic_rel");
    idle(3, "typematic_rel");

    // Opposing keys: A held, then right arrow; releasing A lets right repeat
    send(8'h1C, "opposing");
    send(8'hE0, "opposing");
    send(8'h74, "opposing");
    idle(30, "opposing");
    send(8'hF0, "opposing_rel");
    send(8'h1C, "opposing_rel");
    idle(12, "opposing_rel");
    send(8'hE0, "opposing_rel");
    send(8'hF0, "opposing_rel");
    send(8'h74, "opposing_rel");
    idle(3, "opposing_rel");

    // Diagonal with mixed aliases; W release clears up
    send(8'h1D, "diagonal");
    send(8'hE0, "diagonal");
    send(8'h6B, "diagonal");
    idle(26, "diagonal");
    send(8'hF0, "alias_break");
    send(8'h1D, "alias_break");
    idle(3, "alias_break");
    send(8'hE0, "alias_break");
    send(8'hF0, "alias_break");
    send(8'h6B, "alias_break");
    idle(3, "alias_break");

    // Asynchronous reset between edges, right after an E0 prefix
    send(8'h1D, "async_reset");
    send(8'hE0, "async_reset");
    ps2_key_pressed = 1'b0;
    #3;
    resetn = 1'b0;
    #1;
    model_reset();
    check("async_reset");
    @(posedge clock);
    #2;
    resetn = 1'b1;
    send(8'h75, "fresh_after_reset");
    idle(3, "fresh_after_reset");

    // Self-test byte clears held keys and the repeat timer
    send(8'h1B, "bat_clear");
    send(8'hE0, "bat_clear");
    send(8'h74, "bat_clear");
    idle(4, "bat_clear");
    send(8'hAA, "bat_clear");
    idle(25, "bat_clear");

    // Random traffic over the relevant byte alphabet
    for (int i = 0; i < 500; i++) begin
      logic [7:0] pool [12];
      logic [7:0] b;
      pool = '{8'hE0, 8'hF0, 8'hAA, 8'h75, 8'h72, 8'h6B,
               8'h74, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h00};
      b = pool[$urandom_range(0, 11)];
      if (b == 8'h00) b = 8'($urandom);
      if (b == 8'hAA && $urandom_range(0, 3) != 0) b = 8'hF0;
      send(b, "random");
      idle(int'($urandom_range(0, 7)), "random");
    end
    idle(40, "random_tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
